// File: rtl/button_led_ctrl_if.sv
// Button/LED pin bundle: raw button levels and mode in, LED drive and
// accepted-press total out.
interface button_led_ctrl_if #(
   parameter int N     = 2,
   parameter int CNT_W = 8
);
   logic [N-1:0]     buttons;
   logic [1:0]       mode;
   logic [N-1:0]     leds;
   logic [CNT_W-1:0] press_count;

   modport master (output buttons, output mode, input leds, input press_count);
   modport slave  (input buttons, input mode, output leds, output press_count);
endinterface

// File: rtl/button_led_ctrl.sv
// N-channel button/LED controller: synchronise, debounce, detect presses,
// keep per-channel toggle latches and a wrapping press total, and drive
// the LEDs in momentary, toggle, blink or count-display mode.
module button_led_ctrl #(
   parameter int N               = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BLINK_HALF      = 8,
   parameter int CNT_W           = 8
) (
   input logic              clk,
   input logic              rst,
   button_led_ctrl_if.slave bus
);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      MOMENTARY = 2'b00,
      TOGGLE    = 2'b01,
      BLINK     = 2'b10,
      COUNT     = 2'b11
   } mode_e;

   mode_e            mode_s;
   logic [N-1:0]     meta, sync;
   logic [N-1:0]     db, db_d, press, lat;
   logic [DW-1:0]    dcnt [N];
   logic [BW-1:0]    bcnt;
   logic             phase;
   logic [CNT_W-1:0] cnt_q, pcnt;
   logic [N-1:0]     cnt_led, leds_n, leds_q;

   assign mode_s = mode_e'(bus.mode);
   assign press  = db & ~db_d;

   // Low bits of the press total, zero-padded when the counter is narrower than N
   if (CNT_W >= N) begin : g_cnt_wide
      assign cnt_led = cnt_q[N-1:0];
   end else begin : g_cnt_narrow
      assign cnt_led = {{(N - CNT_W){1'b0}}, cnt_q};
   end

   // Two-flop synchroniser on the raw button pins
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= bus.buttons;
         sync <= meta;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches
   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int unsigned i = 0; i < N; i++) dcnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (sync[i] == db[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DMAX) begin
               db[i]   <= sync[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   // Free-running blink phase shared by all channels
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BMAX) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt + 1'b1;
      end
   end

   // Press popcount and mode-selected LED next state
   always_comb begin
      pcnt   = '0;
      leds_n = '0;
      for (int unsigned i = 0; i < N; i++) pcnt = pcnt + CNT_W'(press[i]);
      case (mode_s)
         MOMENTARY: leds_n = db;
         TOGGLE:    leds_n = lat;
         BLINK:     leds_n = lat & {N{phase}};
         COUNT:     leds_n = cnt_led;
         default:   leds_n = '0;
      endcase
   end

   // Edge-detect delay, toggle latches, wrapping press total and LED register
   always_ff @(posedge clk) begin
      if (rst) begin
         db_d   <= '0;
         lat    <= '0;
         cnt_q  <= '0;
         leds_q <= '0;
      end else begin
         db_d   <= db;
         lat    <= lat ^ press;
         cnt_q  <= cnt_q + pcnt;
         leds_q <= leds_n;
      end
   end

   assign bus.leds        = leds_q;
   assign bus.press_count = cnt_q;
endmodule

// File: doc/button_led_ctrl.md
# button_led_ctrl

Parametrised top-level button/LED controller that replaces the fixed 2-button, 2-LED `main`. It synchronises and debounces N push-buttons and detects presses. It drives N LEDs in one of four run-time modes: momentary, toggle, blink, or press-count display. It sits directly behind the board I/O pins and is the unit the top-level bench instantiates.

## Interface
- `N`, 2, number of button/LED channels (≥1)
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a new button level (≥1)
- `BLINK_HALF`, 8, cycles per blink half-period (≥1)
- `CNT_W`, 8, width of the press counter (≥N bits recommended)

- `clk` in 1: sole clock, rising-edge
- `rst` in 1: synchronous, active-high reset
- `buttons` in N: raw asynchronous button levels, 1 = pressed
- `mode` in 2: 00 MOMENTARY, 01 TOGGLE, 10 BLINK, 11 COUNT
- `leds` out N: registered LED drive
- `press_count` out CNT_W: registered total accepted presses, all channels

## Operation
- Per channel, a 2-FF synchroniser produces `sync[i]`.
- Debounce per channel uses counter `dcnt[i]` and accepted level `db[i]`:
  - `sync[i]==db[i]` → `dcnt` ← 0.
  - Mismatch and `dcnt==DEBOUNCE_CYCLES-1` → `db` ← `sync`, `dcnt` ← 0.
  - Otherwise on mismatch → `dcnt` increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation never changes `db`.
- Press event: `press[i] = db[i] & ~db_d[i]`, where `db_d` is `db` delayed one cycle. It is a one-cycle pulse per accepted rising level. Releases generate no event.
- Toggle latch `lat[i]` inverts on each `press[i]` in every mode. Mode only selects what drives `leds`. Latches are retained across mode changes.
- `press_count` adds popcount(`press`) each cycle. Simultaneous presses on k channels add k in one cycle. The counter wraps modulo 2^CNT_W with no saturation.
- Blink generator is shared and free-running: `bcnt` counts 0..BLINK_HALF-1, and on wrap `phase` inverts.
- LED next-state, registered every cycle:
  - MOMENTARY: `leds` ← `db`
  - TOGGLE: `leds` ← `lat`
  - BLINK: `leds` ← `lat` & {N{`phase`}}
  - COUNT: `leds` ← `press_count[N-1:0]` (zero-extended if CNT_W<N)
- `mode` is sampled every cycle with no hold or handshake. A change takes effect on `leds` at the next edge.
- Buttons held pressed through reset count as a press once debounced after release of `rst`.

## Timing
- Reset (`rst` high at an edge) clears the following to 0 at that edge: sync FFs, `dcnt`, `db`, `db_d`, `lat`, `bcnt`, `phase`, `press_count`, `leds`. Reset mid-debounce or mid-blink discards all progress, with no partial state carried over.
- Button change sampled at edge k:
  - `sync` updates at k+1.
  - `db` updates at k+DEBOUNCE_CYCLES+1.
  - `press` is high during the following cycle.
  - `lat` and `press_count` update at k+DEBOUNCE_CYCLES+2.
- `leds` latency from the button change sampled at edge k:
  - MOMENTARY: `leds` updates at k+DEBOUNCE_CYCLES+2.
  - TOGGLE and COUNT: `leds` updates at k+DEBOUNCE_CYCLES+3.
- Blink after reset deassertion: `phase` first goes to 1 at the BLINK_HALF-th edge. It then inverts every BLINK_HALF edges. `leds` lags `phase` by one edge.
- All outputs are glitch-free registers, with no combinational path from `buttons` or `mode` to any output.

## Test plan
All scenarios use N=2, DEBOUNCE_CYCLES=4, BLINK_HALF=8, CNT_W=8, and a 10-time-unit clock.
- Reset hold: `rst`=1 for 2 edges with `buttons`=2'b11 → `leds`=0 and `press_count`=0. After release in MOMENTARY, `leds`=2'b11 exactly 6 edges after the first sampling edge, and `press_count`=2.
- Bounce rejection: pulse `buttons[0]` high for 3 cycles, then low, in MOMENTARY → `leds` stays 2'b00 and `press_count` stays 0. A 6-cycle press gives `leds[0]`=1 and `press_count`=1.
- Toggle: in TOGGLE, press and release `buttons[1]` three times (10 cycles each level) → `leds[1]` sequence 1,0,1, `leds[0]`=0, `press_count`=3.
- Simultaneous press and COUNT: press both buttons in the same cycle, then switch `mode` to 11 → `press_count` increments by 2 in one cycle, and `leds`=2'b10 on the edge after the mode change.
- Blink: with `lat`=2'b01 and `mode`=10, run 40 cycles → `leds[0]` toggles every 8 cycles, `leds[1]`=0. Switching to TOGGLE shows `leds`=2'b01 on the next edge.
- Wrap and mid-operation reset: 256 single presses → `press_count` returns to 0. Asserting `rst` while `dcnt`=2 means a subsequent 3-cycle-stable input is not accepted.
